hazard_scoreboard_unit: RTL

- Next-generation hazard unit for the in-order pipeline.
- Generalises MEM/WB operand forwarding to NUM_SRC source operands and never forwards register x0.
- Adds load-use stall detection and a per-register scoreboard for long-latency ops (mul/div), with an outstanding-op limit and a saturating stall-cycle counter.
- Sits beside the ID/EX boundary: drives execute-stage forward muxes, the decode freeze, and the ID/EX bubble insert.

---
 rtl/hazard_scoreboard_unit_pkg.sv | 15 +
 rtl/hazard_scoreboard_unit_if.sv | 51 +++++
 rtl/hazard_scoreboard_unit_fwd_select.sv | 26 ++
 rtl/hazard_scoreboard_unit.sv | 100 ++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared definitions for the hazard/scoreboard unit: forward-select encodings
// and the hard-wired zero register.
package hazard_scoreboard_unit_pkg;

  localparam int unsigned FWD_SEL_W = 2;

  typedef enum logic [FWD_SEL_W-1:0] {
    RS_DATA = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-side signal bundle for the hazard unit; master is the pipeline,
// slave is the hazard unit.
interface hazard_scoreboard_unit_if
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned CNT_W   = 32
);
  localparam int unsigned NUM_REGS = 2**ADDR_W;

  logic [NUM_SRC*ADDR_W-1:0]    ex_rs_addr;
  logic [NUM_SRC*ADDR_W-1:0]    dec_rs_addr;
  logic [NUM_SRC-1:0]           dec_rs_used;
  logic [ADDR_W-1:0]            dec_rd_addr;
  logic                         dec_rd_write;
  logic                         dec_is_long;
  logic [ADDR_W-1:0]            ex_rd_addr;
  logic                         ex_is_load;
  logic                         ex_long_issue;
  logic [ADDR_W-1:0]            rd_addr_mem;
  logic                         rd_write_mem;
  logic [ADDR_W-1:0]            rd_addr_wb;
  logic                         rd_write_wb;
  logic                         lu_done;
  logic [ADDR_W-1:0]            lu_rd_addr;
  logic                         flush;
  logic [NUM_SRC*FWD_SEL_W-1:0] fwd_sel;
  logic                         stall_decode;
  logic                         bubble_execute;
  logic [NUM_REGS-1:0]          busy_vec;
  logic [CNT_W-1:0]             stall_cycles;
  logic                         err_spurious;

  modport master (
    output ex_rs_addr, dec_rs_addr, dec_rs_used, dec_rd_addr, dec_rd_write,
           dec_is_long, ex_rd_addr, ex_is_load, ex_long_issue, rd_addr_mem,
           rd_write_mem, rd_addr_wb, rd_write_wb, lu_done, lu_rd_addr, flush,
    input  fwd_sel, stall_decode, bubble_execute, busy_vec, stall_cycles,
           err_spurious
  );

  modport slave (
    input  ex_rs_addr, dec_rs_addr, dec_rs_used, dec_rd_addr, dec_rd_write,
           dec_is_long, ex_rd_addr, ex_is_load, ex_long_issue, rd_addr_mem,
           rd_write_mem, rd_addr_wb, rd_write_wb, lu_done, lu_rd_addr, flush,
    output fwd_sel, stall_decode, bubble_execute, busy_vec, stall_cycles,
           err_spurious
  );

endinterface

// File: rtl/hazard_scoreboard_unit_fwd_select.sv
// Forward-source select for one execute operand: MEM beats WB, x0 never forwards.
module hazard_scoreboard_unit_fwd_select
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rd_mem,
  input  logic              wr_mem,
  input  logic [ADDR_W-1:0] rd_wb,
  input  logic              wr_wb,
  output fwd_sel_e          sel
);
  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(REG_X0);

  always_comb begin
    sel = RS_DATA;
    if (rs != X0) begin
      if (wr_mem && rs == rd_mem)
        sel = FWD_MEM;
      else if (wr_wb && rs == rd_wb)
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit: operand forwarding, load-use detection and a busy-register
// scoreboard for long-latency ops, driving decode freeze and ID/EX bubble.
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  hazard_scoreboard_unit_if.slave hz
);
  localparam int unsigned NUM_REGS = 2**ADDR_W;
  localparam int unsigned OUT_W    = $clog2(MAX_OUT + 1);
  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(REG_X0);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [OUT_W-1:0]    outstanding;
  logic [CNT_W-1:0]    stall_cnt;
  logic                err;
  logic                load_use;
  logic                sb_raw;
  logic                sb_waw;
  logic                full;
  logic                stall;
  logic [ADDR_W-1:0]   src;

  fwd_sel_e sel [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    hazard_scoreboard_unit_fwd_select #(.ADDR_W(ADDR_W)) u_fwd (
      .rs     (hz.ex_rs_addr[i*ADDR_W +: ADDR_W]),
      .rd_mem (hz.rd_addr_mem),
      .wr_mem (hz.rd_write_mem),
      .rd_wb  (hz.rd_addr_wb),
      .wr_wb  (hz.rd_write_wb),
      .sel    (sel[i])
    );
    assign hz.fwd_sel[i*FWD_SEL_W +: FWD_SEL_W] = sel[i];
  end

  always_comb begin
    load_use = 1'b0;
    sb_raw   = 1'b0;
    src      = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src = hz.dec_rs_addr[i*ADDR_W +: ADDR_W];
      if (hz.dec_rs_used[i] && src != X0) begin
        if (hz.ex_is_load && src == hz.ex_rd_addr)
          load_use = 1'b1;
        // An op issuing this cycle is not yet in busy, so match it directly.
        if (busy[src] || (hz.ex_long_issue && src == hz.ex_rd_addr))
          sb_raw = 1'b1;
      end
    end
    sb_waw = hz.dec_rd_write && (hz.dec_rd_addr != X0) && busy[hz.dec_rd_addr];
    full   = hz.dec_is_long &&
             ((32'(outstanding) + 32'(hz.ex_long_issue)) >= MAX_OUT);
    stall  = (load_use | sb_raw | sb_waw | full) & ~hz.flush;
  end

  assign hz.stall_decode   = stall;
  assign hz.bubble_execute = stall | hz.flush;
  assign hz.busy_vec       = busy;
  assign hz.stall_cycles   = stall_cnt;
  assign hz.err_spurious   = err;

  // Clear is applied before set so a same-cycle issue to the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (hz.lu_done)
      busy_nxt[hz.lu_rd_addr] = 1'b0;
    if (hz.ex_long_issue && hz.ex_rd_addr != X0)
      busy_nxt[hz.ex_rd_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      outstanding <= '0;
      stall_cnt   <= '0;
      err         <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (hz.ex_long_issue && !hz.lu_done && outstanding != '1)
        outstanding <= outstanding + 1'b1;
      else if (hz.lu_done && !hz.ex_long_issue && outstanding != '0)
        outstanding <= outstanding - 1'b1;
      if (hz.lu_done && (outstanding == '0 || !busy[hz.lu_rd_addr]))
        err <= 1'b1;
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
